// File: rtl/sdram_frame_writer_pkg.sv
// Shared definitions for the SDRAM frame writer: FSM encodings, default
// burst length, frame geometry and frame-buffer base addresses.
package sdram_frame_writer_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_REQ       = 3'd2,
        ST_BURST     = 3'd3,
        ST_WAIT_DONE = 3'd4
    } wr_state_e;

    localparam int DEF_BURST_LEN   = 256;
    localparam int DEF_FRAME_WORDS = 307200;
    localparam int DEF_ADDR_W      = 22;

    localparam logic [21:0] DEF_FRAME_BASE0 = 22'h000000;
    localparam logic [21:0] DEF_FRAME_BASE1 = 22'h080000;

    // Word counter width; a VGA frame (307200 words) fits in 20 bits.
    localparam int WORD_CNT_W = 20;
    localparam int RUSEDW_W   = 11;

    // Width of a down-counter that must hold the value burst_len.
    function automatic int beat_cnt_width(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/sdram_frame_writer_addr_gen.sv
// frame_addr_gen: word counter, write-bank register and burst start address.
// Build option SDRAM_WR_PINGPONG_EN: when defined the write bank toggles at
// every completed frame; otherwise the writer stays on FRAME_BASE0.
module frame_addr_gen
    import sdram_frame_writer_pkg::*;
#(
    parameter int                BURST_LEN   = DEF_BURST_LEN,
    parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] FRAME_BASE0 = ADDR_W'(DEF_FRAME_BASE0),
    parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(DEF_FRAME_BASE1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              advance,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              frame_full,
    output logic              bank
);

    localparam logic [WORD_CNT_W-1:0] STEP       = WORD_CNT_W'(BURST_LEN);
    localparam logic [WORD_CNT_W-1:0] LAST_START = WORD_CNT_W'(FRAME_WORDS - BURST_LEN);

    logic [WORD_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  bank_q, bank_d;

    // frame_full flags the burst in flight as the last one of the frame, so
    // the FSM can finish the frame in the same cycle it sees wr_done.
    assign frame_full = (cnt_q == LAST_START);
    assign wr_addr    = addr_q;
    assign bank       = bank_q;

    // Next-state: restart rewinds to the bank base, advance steps one burst.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        bank_d = bank_q;
        if (restart) begin
            cnt_d  = '0;
            addr_d = bank_q ? FRAME_BASE1 : FRAME_BASE0;
        end else if (advance) begin
            cnt_d  = cnt_q + STEP;
            addr_d = addr_q + ADDR_W'(BURST_LEN);
`ifdef SDRAM_WR_PINGPONG_EN
            if (frame_full) begin
                bank_d = ~bank_q;
            end
`endif
        end
    end

    // Counter, address and bank registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            addr_q <= FRAME_BASE0;
            bank_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            bank_q <= bank_d;
        end
    end

endmodule

// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: drains the camera write FIFO into SDRAM burst writes,
// one frame per buffer, and reports the newest complete buffer on rd_bank.
// Build option SDRAM_WR_PINGPONG_EN (used in frame_addr_gen) selects
// double buffering; without it every frame lands at FRAME_BASE0.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_HOLD      | no frame in progress; wait for frame_start / pending
//   ST_IDLE      | frame open; wait for a full burst in the FIFO
//   ST_REQ       | wr_req held until the controller acks
//   ST_BURST     | one FIFO read per wr_data_req, BURST_LEN in total
//   ST_WAIT_DONE | wait for wr_done, then step address / finish frame
module sdram_frame_writer
    import sdram_frame_writer_pkg::*;
#(
    parameter int                BURST_LEN   = DEF_BURST_LEN,
    parameter int                FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] FRAME_BASE0 = ADDR_W'(DEF_FRAME_BASE0),
    parameter logic [ADDR_W-1:0] FRAME_BASE1 = ADDR_W'(DEF_FRAME_BASE1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                frame_start,
    input  logic [RUSEDW_W-1:0] fifo_rusedw,
    input  logic [15:0]         fifo_q,
    output logic                fifo_rdreq,
    output logic                fifo_clr,
    output logic                wr_req,
    input  logic                wr_ack,
    output logic [ADDR_W-1:0]   wr_addr,
    input  logic                wr_data_req,
    output logic [15:0]         wr_data,
    input  logic                wr_done,
    output logic                rd_bank,
    output logic                frame_done,
    output logic                overrun
);

    localparam int                    BEAT_W      = beat_cnt_width(BURST_LEN);
    localparam logic [BEAT_W-1:0]     BEATS_FULL  = BEAT_W'(BURST_LEN);
    localparam logic [RUSEDW_W-1:0]   BURST_AVAIL = RUSEDW_W'(BURST_LEN);

    if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_frame_words_chk
        $error("FRAME_WORDS must be a multiple of BURST_LEN");
    end
    if (BURST_LEN >= (1 << RUSEDW_W)) begin : g_burst_len_chk
        $error("BURST_LEN must be representable in fifo_rusedw");
    end

    wr_state_e         state_q, state_d;
    logic [BEAT_W-1:0] beats_q, beats_d;
    logic              pend_q, pend_d;
    logic              wr_req_q, wr_req_d;
    logic              fifo_clr_q, fifo_clr_d;
    logic              frame_done_q, frame_done_d;
    logic              rd_bank_q, rd_bank_d;
    logic              overrun_q, overrun_d;

    logic              restart;
    logic              advance;
    logic              frame_full;
    logic              bank;
    logic              rd_strobe;

    frame_addr_gen #(
        .BURST_LEN   (BURST_LEN),
        .FRAME_WORDS (FRAME_WORDS),
        .ADDR_W      (ADDR_W),
        .FRAME_BASE0 (FRAME_BASE0),
        .FRAME_BASE1 (FRAME_BASE1)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .advance    (advance),
        .wr_addr    (wr_addr),
        .frame_full (frame_full),
        .bank       (bank)
    );

    // beats_q counts down the strobes still owed in this burst; a strobe
    // arriving with nothing owed is an overrun and never reaches the FIFO.
    assign rd_strobe = wr_data_req && (state_q == ST_BURST) && (beats_q != '0);

    // Next-state and output decode.
    always_comb begin
        state_d      = state_q;
        beats_d      = beats_q;
        restart      = 1'b0;
        advance      = 1'b0;
        frame_done_d = 1'b0;
        rd_bank_d    = rd_bank_q;
        pend_d       = pend_q || (frame_start &&
                       (state_q inside {ST_REQ, ST_BURST, ST_WAIT_DONE}));
        overrun_d    = overrun_q || (wr_data_req && !rd_strobe);

        case (state_q)
            ST_HOLD: begin
                if (frame_start || pend_q) begin
                    restart = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // IDLE is only ever entered with the frame still incomplete.
                if (frame_start) begin
                    restart = 1'b1;
                end else if (fifo_rusedw >= BURST_AVAIL) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wr_ack) begin
                    beats_d = BEATS_FULL;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (rd_strobe) begin
                    beats_d = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) begin
                        state_d = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (wr_done) begin
                    advance = 1'b1;
                    if (frame_full) begin
                        frame_done_d = 1'b1;
                        rd_bank_d    = bank;
                        state_d      = ST_HOLD;
                    end else if (pend_d) begin
                        // Abandon the partial frame; HOLD replays the start.
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_HOLD;
        endcase

        wr_req_d   = (state_d == ST_REQ);
        fifo_clr_d = restart;
    end

    // State and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HOLD;
            beats_q      <= '0;
            pend_q       <= 1'b0;
            wr_req_q     <= 1'b0;
            fifo_clr_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rd_bank_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_q      <= beats_d;
            pend_q       <= pend_d;
            wr_req_q     <= wr_req_d;
            fifo_clr_q   <= fifo_clr_d;
            frame_done_q <= frame_done_d;
            rd_bank_q    <= rd_bank_d;
            overrun_q    <= overrun_d;
        end
    end

    assign fifo_rdreq = rd_strobe;
    assign wr_data    = fifo_q;
    assign wr_req     = wr_req_q;
    assign fifo_clr   = fifo_clr_q;
    assign frame_done = frame_done_q;
    assign rd_bank    = rd_bank_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Directed bench for sdram_frame_writer with a short frame (6 bursts of 256).
module tb_sdram_frame_writer;

    localparam int BL = 256;
    localparam int FW = 6 * BL;

`ifdef SDRAM_WR_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [10:0] fifo_rusedw;
    logic [15:0] fifo_q;
    logic        fifo_rdreq;
    logic        fifo_clr;
    logic        wr_req;
    logic        wr_ack;
    logic [21:0] wr_addr;
    logic        wr_data_req;
    logic [15:0] wr_data;
    logic        wr_done;
    logic        rd_bank;
    logic        frame_done;
    logic        overrun;

    int passed = 0;
    int total  = 0;
    int fidx   = 0;
    int exp_idx = 0;
    logic fd, rb;
    logic [21:0] b2;

    sdram_frame_writer #(
        .BURST_LEN   (BL),
        .FRAME_WORDS (FW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .fifo_rusedw (fifo_rusedw),
        .fifo_q      (fifo_q),
        .fifo_rdreq  (fifo_rdreq),
        .fifo_clr    (fifo_clr),
        .wr_req      (wr_req),
        .wr_ack      (wr_ack),
        .wr_addr     (wr_addr),
        .wr_data_req (wr_data_req),
        .wr_data     (wr_data),
        .wr_done     (wr_done),
        .rd_bank     (rd_bank),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word(input int i);
        return 16'(i * 37 + 16'h5a00);
    endfunction

    // FIFO model: read data appears one cycle after each read strobe.
    always @(posedge clk) begin
        if (fifo_rdreq === 1'b1) begin
            fifo_q <= word(fidx);
            fidx   <= fidx + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One controller-side burst: ack, BURST_LEN data strobes, wr_done.
    task automatic run_burst(input logic [21:0] exp_addr, input int fs_beat,
                             input bit extra_req, output logic fd_o, output logic rb_o);
        int n = 0;
        int rd = 0;
        int derr = 0;
        while (wr_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("wr_req_rise", wr_req, 1);
        check("wr_addr", wr_addr, exp_addr);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        check("wr_req_fall", wr_req, 0);
        for (int i = 0; i < BL; i++) begin
            wr_data_req = 1'b1;
            frame_start = (i == fs_beat);
            #1;
            if (fifo_rdreq === 1'b1) rd++;
            @(negedge clk);
            if (wr_data !== word(exp_idx)) derr++;
            exp_idx++;
        end
        frame_start = 1'b0;
        if (extra_req) begin
            wr_data_req = 1'b1;
            #1;
            check("extra_rdreq", fifo_rdreq, 0);
            @(negedge clk);
        end
        wr_data_req = 1'b0;
        check("rdreq_count", rd, BL);
        check("data_errors", derr, 0);
        wr_done = 1'b1;
        @(negedge clk);
        wr_done = 1'b0;
        fd_o = frame_done;
        rb_o = rd_bank;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; frame_start = 1'b0; fifo_rusedw = '0; wr_ack = 1'b0;
        wr_data_req = 1'b0; wr_done = 1'b0; fifo_q = '0;
        b2 = PP ? 22'h080000 : 22'h000000;
        @(negedge clk);
        @(negedge clk);
        check("rst_rdreq", fifo_rdreq, 0);
        check("rst_clr", fifo_clr, 0);
        check("rst_wr_req", wr_req, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_wr_addr", wr_addr, 22'h000000);
        rst_n = 1'b1;
        fifo_rusedw = 11'd300;
        repeat (5) @(negedge clk);
        check("hold_no_req", wr_req, 0);

        // Frame 1 into bank 0.
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("f1_clr", fifo_clr, 1);
        check("f1_base", wr_addr, 22'h000000);
        @(negedge clk);
        check("f1_clr_pulse", fifo_clr, 0);
        run_burst(22'h000000, -1, 1'b0, fd, rb);
        check("f1_b0_fd", fd, 0);
        fifo_rusedw = 11'd255;
        repeat (10) @(negedge clk);
        check("thresh_255", wr_req, 0);
        check("addr_step", wr_addr, 22'h000100);
        fifo_rusedw = 11'd256;
        @(negedge clk);
        check("thresh_256", wr_req, 1);
        for (int k = 1; k < 6; k++) begin
            run_burst(22'(k * BL), -1, 1'b0, fd, rb);
            check("f1_fd", fd, (k == 5));
        end
        check("f1_rd_bank", rb, 0);
        @(negedge clk);
        check("f1_fd_pulse", frame_done, 0);
        repeat (3) @(negedge clk);
        check("f1_hold_no_req", wr_req, 0);
        check("f1_end_addr", wr_addr, 22'h000600);

        // Frame 2, aborted by frame_start during burst 5.
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("f2_clr", fifo_clr, 1);
        check("f2_base", wr_addr, b2);
        for (int k = 0; k < 4; k++) begin
            run_burst(b2 + 22'(k * BL), -1, 1'b0, fd, rb);
        end
        run_burst(b2 + 22'h000400, 100, 1'b0, fd, rb);
        check("abort_no_fd", fd, 0);
        @(negedge clk);
        check("abort_clr", fifo_clr, 1);
        check("abort_base", wr_addr, b2);
        check("abort_rd_bank", rd_bank, 0);

        // Restarted frame 2; frame_start in IDLE rewinds in place.
        run_burst(b2, -1, 1'b0, fd, rb);
        fifo_rusedw = 11'd0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("idle_clr", fifo_clr, 1);
        check("idle_base", wr_addr, b2);
        check("idle_no_req", wr_req, 0);
        fifo_rusedw = 11'd256;
        for (int k = 0; k < 6; k++) begin
            run_burst(b2 + 22'(k * BL), -1, 1'b0, fd, rb);
        end
        check("f2_fd", fd, 1);
        check("f2_rd_bank", rb, PP);

        // Frame 3 with an overrun strobe.
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check("f3_base", wr_addr, 22'h000000);
        check("pre_overrun", overrun, 0);
        run_burst(22'h000000, -1, 1'b1, fd, rb);
        check("overrun_set", overrun, 1);
        run_burst(22'h000100, -1, 1'b0, fd, rb);
        check("overrun_sticky", overrun, 1);

        // Reset in the middle of a burst.
        n = 0;
        while (wr_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_req", wr_req, 1);
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        repeat (10) begin
            wr_data_req = 1'b1;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdreq", fifo_rdreq, 0);
        check("mid_rst_wr_req", wr_req, 0);
        check("mid_rst_addr", wr_addr, 22'h000000);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_rd_bank", rd_bank, 0);
        wr_data_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_hold", wr_req, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sdram_frame_writer.md
# sdram_frame_writer

Drains the camera-side write FIFO and turns its contents into SDRAM burst-write requests with frame-aligned addressing. It is the reader side of the FIFO that the OV7670 capture path fills, and it sits between that FIFO and the SDRAM controller's write port in the `sdram_ctrl_clk` domain. It alternates completed frames between two frame buffers. It tells the display path which buffer holds the newest complete frame.

## Interface
Parameters:
- `BURST_LEN`, 256: words per SDRAM write burst.
- `FRAME_WORDS`, 307200: 16-bit words per frame (640×480). Must be a multiple of `BURST_LEN`; elaboration fails otherwise.
- `ADDR_W`, 22: SDRAM word-address width.
- `FRAME_BASE0`, 22'h000000: base word address of buffer 0.
- `FRAME_BASE1`, 22'h080000: base word address of buffer 1.

Ports:
- `clk` in 1: controller clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: one-cycle pulse per camera frame, already synchronised to `clk`.
- `fifo_rusedw` in 11: words available in the write FIFO.
- `fifo_q` in 16: FIFO read data, valid one cycle after `fifo_rdreq`.
- `fifo_rdreq` out 1: FIFO read strobe.
- `fifo_clr` out 1: one-cycle FIFO flush pulse.
- `wr_req` out 1: burst request to the SDRAM controller.
- `wr_ack` in 1: controller accepted the request (one-cycle pulse).
- `wr_addr` out ADDR_W: burst start word address.
- `wr_data_req` in 1: controller wants one data word on the next cycle.
- `wr_data` out 16: write data.
- `wr_done` in 1: burst complete (one-cycle pulse).
- `rd_bank` out 1: buffer holding the newest complete frame.
- `frame_done` out 1: one-cycle pulse when a frame is fully written.
- `overrun` out 1: sticky protocol-error flag.

## Operation
- States:
  - `HOLD`: reset state; waits for `frame_start`.
  - `IDLE`: waits until `fifo_rusedw >= BURST_LEN` and the frame is incomplete.
  - `REQ`: holds `wr_req`.
  - `BURST`: streams data.
  - `WAIT_DONE`: waits for `wr_done`.
- `HOLD`→`IDLE` on `frame_start`. In the same cycle:
  - pulse `fifo_clr`;
  - clear the word counter;
  - set `wr_addr` to the write bank's base.
- `IDLE`→`REQ` when a full burst is available.
- `REQ`→`BURST` on `wr_ack`.
- In `BURST`:
  - `fifo_rdreq` is the combinational AND of `wr_data_req` and (`state == BURST` and beat count < `BURST_LEN`);
  - `wr_data` = `fifo_q` directly;
  - after `BURST_LEN` strobes, go to `WAIT_DONE`.
- `WAIT_DONE`→ on `wr_done`:
  - `wr_addr += BURST_LEN` and counter `+= BURST_LEN`;
  - if counter == `FRAME_WORDS`: pulse `frame_done`, set `rd_bank` to the finished bank, toggle the write bank, go to `HOLD`;
  - otherwise go to `IDLE`.
- `frame_start` outside `HOLD`/`IDLE` (mid-burst): latch it as pending. The burst completes. Then apply the `HOLD`→`IDLE` actions. The partial frame is discarded: `rd_bank` is unchanged and the write bank is not toggled.
- `frame_start` in `IDLE`: restart the frame in place (same bank, address back to base, `fifo_clr`).
- `wr_data_req` beyond `BURST_LEN` in one burst, or outside `BURST`: ignored (no FIFO read); sets `overrun`. `overrun` is cleared only by reset.
- Address arithmetic: unsigned, `ADDR_W` bits. The counter is 20 bits and never exceeds `FRAME_WORDS`.

## Timing
- Reset values:
  - `fifo_rdreq`, `fifo_clr`, `wr_req`, `frame_done`, `overrun`, `rd_bank` = 0;
  - `wr_addr` = `FRAME_BASE0`;
  - state = `HOLD`, write bank = 0.
- `wr_req` rises the cycle after entering `REQ` and stays high through the `wr_ack` cycle. It falls the cycle after `wr_ack`. `wr_addr` is stable while `wr_req` is high.
- `fifo_rdreq` has zero-cycle latency from `wr_data_req`. `wr_data` reaches the controller one cycle after each strobe.
- `frame_done` and the `rd_bank` update occur in the same cycle, one cycle after the final `wr_done`.
- Minimum request-to-request gap: 2 cycles (`WAIT_DONE`→`IDLE`→`REQ`).
- Reset mid-burst: everything returns to reset values immediately. The controller is expected to be reset by the same `rst_n`.

## Configuration
- `SDRAM_WR_PINGPONG_EN` defined: alternate buffers 0/1 as described.
- Not defined:
  - single buffer at `FRAME_BASE0`; the write bank never toggles;
  - `rd_bank` is constant 0;
  - `frame_done` still pulses.

## Structure
- Add to the shared SDRAM parameter header (`sdram_para.v`): the state encodings, default `BURST_LEN`, and the frame base addresses.
- One sub-module, `frame_addr_gen`: owns the word counter, the bank register, and `wr_addr`. Inputs: `restart`, `advance`. Outputs: `frame_full` and `bank`.

## Test plan
- Reset then a `frame_start` pulse → `fifo_clr` = 1 for 1 cycle. With `fifo_rusedw` = 300, `wr_req` rises with `wr_addr` = 0x000000.
- Full burst: `wr_ack`, then 256 `wr_data_req` strobes and `wr_done` → 256 `fifo_rdreq` pulses, FIFO words reach `wr_data` in order, next `wr_addr` = 0x000100.
- 1200 bursts → `frame_done` pulse and `rd_bank` = 0. Next frame writes from 0x080000. With the macro undefined, it writes from 0x000000 and `rd_bank` stays 0.
- `frame_start` during burst 5 → burst 5 completes. Then `fifo_clr` pulses, `wr_addr` returns to the bank base, `rd_bank` is unchanged.
- `fifo_rusedw` = 255 held → `wr_req` never asserts. At 256 it asserts on the next cycle.
- 257th `wr_data_req` in one burst → no extra `fifo_rdreq`; `overrun` = 1 until reset.
